// File: rtl/uart_rx.sv
// 8N1 serial receiver: synchronises rx, samples each bit at its midpoint and
// holds one byte for the CPU with full/read handshake and sticky error flags.
module uart_rx #(
    parameter int CLKS_PER_BIT = 16
) (
    input  logic       dblclk,
    input  logic       reset,
    input  logic       rx,
    input  logic       rd,
    output logic [7:0] rxdata,
    output logic       rxfull,
    output logic       overrun,
    output logic       frame_err,
    output logic       busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] clkcnt_q, clkcnt_d;
    logic [2:0]    bitcnt_q, bitcnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    rxdata_q, rxdata_d;
    logic          rxfull_q, rxfull_d;
    logic          overrun_q, overrun_d;
    logic          frame_err_q, frame_err_d;
    logic          rx_meta_q, rx_meta_d;
    logic          rx_s_q, rx_s_d;

    always_comb begin
        rx_meta_d   = rx;
        rx_s_d      = rx_meta_q;
        state_d     = state_q;
        clkcnt_d    = clkcnt_q;
        bitcnt_d    = bitcnt_q;
        shift_d     = shift_q;
        rxdata_d    = rxdata_q;
        rxfull_d    = rxfull_q;
        overrun_d   = overrun_q;
        frame_err_d = frame_err_q;

        if (rd) begin
            rxfull_d    = 1'b0;
            overrun_d   = 1'b0;
            frame_err_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rx_s_q) begin
                    state_d  = S_START;
                    clkcnt_d = '0;
                end
            end
            S_START: begin
                if (clkcnt_q == HALF_LAST) begin
                    clkcnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                    end else begin
                        state_d  = S_DATA;
                        bitcnt_d = 3'd0;
                    end
                end else begin
                    clkcnt_d = clkcnt_q + CW'(1);
                end
            end
            S_DATA: begin
                if (clkcnt_q == BIT_LAST) begin
                    clkcnt_d = '0;
                    shift_d  = {rx_s_q, shift_q[7:1]};
                    bitcnt_d = bitcnt_q + 3'd1;
                    if (bitcnt_q == 3'd7) state_d = S_STOP;
                end else begin
                    clkcnt_d = clkcnt_q + CW'(1);
                end
            end
            S_STOP: begin
                if (clkcnt_q == BIT_LAST) begin
                    clkcnt_d = '0;
                    if (rx_s_q) begin
                        state_d = S_IDLE;
                        // A read in this same cycle frees the holding register.
                        if (!rxfull_q || rd) begin
                            rxdata_d = shift_q;
                            rxfull_d = 1'b1;
                        end else begin
                            overrun_d = 1'b1;
                        end
                    end else begin
                        state_d = S_BREAK;
                        if (!rd) frame_err_d = 1'b1;
                    end
                end else begin
                    clkcnt_d = clkcnt_q + CW'(1);
                end
            end
            S_BREAK: begin
                if (rx_s_q) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge dblclk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            clkcnt_q    <= '0;
            bitcnt_q    <= 3'd0;
            shift_q     <= 8'h00;
            rxdata_q    <= 8'h00;
            rxfull_q    <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            rx_meta_q   <= 1'b1;
            rx_s_q      <= 1'b1;
        end else begin
            state_q     <= state_d;
            clkcnt_q    <= clkcnt_d;
            bitcnt_q    <= bitcnt_d;
            shift_q     <= shift_d;
            rxdata_q    <= rxdata_d;
            rxfull_q    <= rxfull_d;
            overrun_q   <= overrun_d;
            frame_err_q <= frame_err_d;
            rx_meta_q   <= rx_meta_d;
            rx_s_q      <= rx_s_d;
        end
    end

    assign rxdata    = rxdata_q;
    assign rxfull    = rxfull_q;
    assign overrun   = overrun_q;
    assign frame_err = frame_err_q;
    assign busy      = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: directed test-plan frames plus random frames and random
// reads, checked every cycle against an event-driven model of the receiver.
module tb_uart_rx;
    localparam int CPB    = 16;
    localparam int HALF   = CPB / 2;
    // Line-edge-relative timing: 2 sync flops + 1 idle detect, then mid start
    // bit, 8 data bits and the stop bit, each one bit period later.
    localparam int T_ON   = 3;
    localparam int T_DONE = 3 + HALF + 9 * CPB;

    localparam int EV_ON  = 0;
    localparam int EV_OFF = 1;
    localparam int EV_DLV = 2;
    localparam int EV_FER = 3;

    logic       dblclk = 1'b0;
    logic       reset  = 1'b1;
    logic       rx     = 1'b1;
    logic       rd     = 1'b0;
    logic       rd_man = 1'b0;
    logic       rnd_en = 1'b0;
    logic [7:0] rxdata;
    logic       rxfull, overrun, frame_err, busy;

    uart_rx #(.CLKS_PER_BIT(CPB)) dut (
        .dblclk   (dblclk),
        .reset    (reset),
        .rx       (rx),
        .rd       (rd),
        .rxdata   (rxdata),
        .rxfull   (rxfull),
        .overrun  (overrun),
        .frame_err(frame_err),
        .busy     (busy)
    );

    always #5 dblclk = ~dblclk;

    int cyc    = 0;
    int ntests = 0;
    int nfail  = 0;
    logic chk_en = 1'b0;

    typedef struct {
        int         at;
        int         kind;
        logic [7:0] data;
    } ev_t;
    ev_t evq[$];

    logic [7:0] m_data = 8'h00;
    logic       m_full = 1'b0;
    logic       m_ovr  = 1'b0;
    logic       m_ferr = 1'b0;
    logic       m_busy = 1'b0;

    function automatic void push_ev(int at, int kind, logic [7:0] d);
        ev_t e;
        e.at   = at;
        e.kind = kind;
        e.data = d;
        evq.push_back(e);
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        ntests++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Model: holding register and flags, updated by frame events at the edge
    // on which the receiver finishes each stop-bit decision.
    always @(posedge dblclk) begin
        logic r, pre_full;
        cyc++;
        if (reset) begin
            m_data = 8'h00; m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0; m_busy = 1'b0;
            evq.delete();
        end else begin
            r        = rd;
            pre_full = m_full;
            if (r) begin
                m_full = 1'b0; m_ovr = 1'b0; m_ferr = 1'b0;
            end
            for (int i = evq.size() - 1; i >= 0; i--) begin
                if (evq[i].at == cyc) begin
                    case (evq[i].kind)
                        EV_ON:  m_busy = 1'b1;
                        EV_OFF: m_busy = 1'b0;
                        EV_DLV: begin
                            if (!pre_full || r) begin
                                m_data = evq[i].data;
                                m_full = 1'b1;
                            end else begin
                                m_ovr = 1'b1;
                            end
                        end
                        default: if (!r) m_ferr = 1'b1;
                    endcase
                    evq.delete(i);
                end
            end
        end
    end

    always @(negedge dblclk) begin
        if (chk_en) begin
            check("rxdata",    32'(rxdata),    32'(m_data));
            check("rxfull",    32'(rxfull),    32'(m_full));
            check("overrun",   32'(overrun),   32'(m_ovr));
            check("frame_err", 32'(frame_err), 32'(m_ferr));
            check("busy",      32'(busy),      32'(m_busy));
        end
    end

    initial begin
        forever begin
            @(posedge dblclk);
            #2;
            rd = rd_man || (rnd_en && ($urandom_range(0, 7) == 0));
        end
    end

    task automatic wait_cyc(int n);
        repeat (n) begin
            @(posedge dblclk);
            #1;
        end
    endtask

    task automatic pulse_rd();
        rd_man = 1'b1;
        wait_cyc(1);
        rd_man = 1'b0;
    endtask

    task automatic drive_frame(input logic [7:0] b, input logic stop, input int hold);
        int k;
        k = cyc;
        push_ev(k + T_ON, EV_ON, 8'h00);
        if (stop) begin
            push_ev(k + T_DONE, EV_DLV, b);
            push_ev(k + T_DONE, EV_OFF, 8'h00);
        end else begin
            push_ev(k + T_DONE, EV_FER, 8'h00);
        end
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            wait_cyc(CPB);
        end
        rx = stop;
        wait_cyc(CPB);
        if (!stop) begin
            wait_cyc(hold);
            rx = 1'b1;
            push_ev(cyc + 3, EV_OFF, 8'h00);
            wait_cyc(2);
        end
    endtask

    initial begin
        #(10 * 60000);
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        wait_cyc(3);
        reset = 1'b0;
        wait_cyc(1);
        chk_en = 1'b1;
        check("rst_rxdata", 32'(rxdata), 32'h00);
        check("rst_rxfull", 32'(rxfull), 32'h0);
        check("rst_overrun", 32'(overrun), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        wait_cyc(5);

        drive_frame(8'hA5, 1'b1, 0);
        check("a5_rxdata", 32'(rxdata), 32'hA5);
        check("a5_model", 32'(m_data), 32'hA5);
        check("a5_rxfull", 32'(rxfull), 32'h1);
        check("a5_flags", 32'({overrun, frame_err, busy}), 32'h0);
        pulse_rd();
        check("a5_rd_rxfull", 32'(rxfull), 32'h0);
        wait_cyc(4);

        drive_frame(8'h3C, 1'b1, 0);
        drive_frame(8'hC3, 1'b1, 0);
        check("ovr_rxdata", 32'(rxdata), 32'h3C);
        check("ovr_rxfull", 32'(rxfull), 32'h1);
        check("ovr_overrun", 32'(overrun), 32'h1);
        pulse_rd();
        check("ovr_rd_rxfull", 32'(rxfull), 32'h0);
        check("ovr_rd_overrun", 32'(overrun), 32'h0);
        wait_cyc(4);

        drive_frame(8'h81, 1'b0, 40);
        check("fe_frame_err", 32'(frame_err), 32'h1);
        check("fe_rxfull", 32'(rxfull), 32'h0);
        wait_cyc(30);
        check("fe_no_byte", 32'(rxfull), 32'h0);
        check("fe_idle", 32'(busy), 32'h0);
        pulse_rd();
        check("fe_rd_clear", 32'(frame_err), 32'h0);

        k = cyc;
        push_ev(k + T_ON, EV_ON, 8'h00);
        push_ev(k + T_ON + HALF, EV_OFF, 8'h00);
        rx = 1'b0;
        wait_cyc(5);
        rx = 1'b1;
        wait_cyc(30);
        check("glitch_flags", 32'({rxfull, overrun, frame_err, busy}), 32'h0);

        k = cyc;
        push_ev(k + T_ON, EV_ON, 8'h00);
        push_ev(k + T_DONE, EV_DLV, 8'h96);
        push_ev(k + T_DONE, EV_OFF, 8'h00);
        rx = 1'b0;
        wait_cyc(CPB);
        for (int i = 0; i < 4; i++) begin
            rx = (8'h96 >> i) & 8'h01;
            wait_cyc(CPB);
        end
        rx = 1'b0;
        wait_cyc(HALF);
        reset = 1'b1;
        rx    = 1'b1;
        wait_cyc(2);
        check("rst_mid_outputs", 32'({rxdata, rxfull, overrun, frame_err, busy}), 32'h0);
        reset = 1'b0;
        wait_cyc(200);
        check("rst_mid_no_byte", 32'(rxfull), 32'h0);
        drive_frame(8'h5A, 1'b1, 0);
        check("5a_rxdata", 32'(rxdata), 32'h5A);
        check("5a_rxfull", 32'(rxfull), 32'h1);
        pulse_rd();

        drive_frame(8'h11, 1'b1, 0);
        check("11_rxdata", 32'(rxdata), 32'h11);
        fork
            drive_frame(8'h22, 1'b1, 0);
            begin
                wait_cyc(T_DONE - 1);
                rd_man = 1'b1;
                wait_cyc(1);
                rd_man = 1'b0;
            end
        join
        check("rdstop_rxdata", 32'(rxdata), 32'h22);
        check("rdstop_rxfull", 32'(rxfull), 32'h1);
        check("rdstop_overrun", 32'(overrun), 32'h0);
        pulse_rd();

        rnd_en = 1'b1;
        for (int n = 0; n < 40; n++) begin
            drive_frame(8'($urandom), ($urandom_range(0, 5) != 0), int'($urandom_range(0, 20)));
            wait_cyc(int'($urandom_range(0, 12)));
        end
        rnd_en = 1'b0;
        wait_cyc(20);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver for the CPU's UART link; the opposite direction to the existing 8-bit transmit path.
- Samples an asynchronous 8N1 line (1 start bit, 8 data bits LSB first, 1 stop bit) at CLKS_PER_BIT clocks per bit.
- Holds one received byte for the CPU, with a full/read handshake plus overrun and framing-error flags.
- Sits beside the transmitter in the top level; the CPU reads rxdata as two nibbles, so the byte stays stable until rd.

Parameters:
- CLKS_PER_BIT, 16, dblclk cycles per serial bit; must be an even number ≥ 4.

Ports:
- dblclk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high reset.
- rx  input  1  asynchronous serial line; idles high.
- rd  input  1  one-cycle strobe: CPU has consumed the held byte; clears rxfull, overrun and frame_err.
- rxdata  output  8  held received byte.
- rxfull  output  1  rxdata holds an unread byte.
- overrun  output  1  sticky: a byte arrived while rxfull=1 and was discarded.
- frame_err  output  1  sticky: stop bit sampled low.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
Reset and input synchronisation:
- Reset (dblclk edge with reset=1): rxdata=8'h00, rxfull=0, overrun=0, frame_err=0, busy=0, FSM=IDLE, counters=0.
- Both synchroniser flops are set to 1.
- Reset mid-frame aborts the frame; the partial byte is never delivered.
- rx passes through a 2-flop synchroniser (rx_s). All FSM decisions use rx_s, so there are 2 cycles of input latency.
- The clock counter is $clog2(CLKS_PER_BIT) bits wide and wraps to 0 on each sample point. The bit counter is 3 bits.

FSM states:
- IDLE: when rx_s=0, go to START with clkcnt=0.
- START: wait until clkcnt = CLKS_PER_BIT/2-1, then re-sample (mid start bit).
  - rx_s=1: false start, return to IDLE with no flags changed.
  - rx_s=0: go to DATA with clkcnt=0 and bitcnt=0.
- DATA: on each clkcnt = CLKS_PER_BIT-1, shift rx_s into shift[7] (right shift, so LSB is received first) and increment bitcnt.
  - After the 8th sample, go to STOP.
- STOP: at clkcnt = CLKS_PER_BIT-1, sample rx_s.
  - rx_s=1 and (rxfull=0 or rd=1 this cycle): on the next edge rxdata ← shift and rxfull=1. Go to IDLE.
  - rx_s=1 and rxfull=1 and rd=0: byte discarded, overrun ← 1, rxdata unchanged. Go to IDLE.
  - rx_s=0: byte discarded, frame_err ← 1. Go to BREAK.
- BREAK: wait for rx_s=1, then go to IDLE. This prevents a held-low line from retriggering a start.

Handshake:
- rd with rxfull=0 is harmless; it still clears overrun and frame_err.
- rd in the same cycle as a stop-bit delivery: new byte loaded, rxfull stays 1, flags cleared, and the new event's flag is not set.
- rd in the same cycle as an overrun or framing detection: flags end at 0, and rd takes precedence for the existing byte (rxfull cleared).
- Frame timing: end of stop sample to rxfull rising is 1 cycle.
- Earliest next start detection is the cycle after returning to IDLE, so back-to-back frames with zero idle time are received.

Test Plan:
- CLKS_PER_BIT=16; send 8'hA5 at exactly 16 clk/bit -> rxfull rises 1 cycle after stop mid-sample; rxdata=8'hA5; overrun=0; frame_err=0; busy low afterwards.
- Send 8'h3C then 8'hC3 back-to-back, no rd -> rxdata=8'h3C, rxfull=1, overrun=1; then rd -> rxfull=0, overrun=0.
- Send 8'h81 with stop bit driven low, then hold rx low 40 cycles -> frame_err=1, rxfull=0, busy stays 1 until rx returns high, then no spurious byte.
- Pulse rx low for 5 cycles only (glitch) -> returns to IDLE, no flags set, rxfull=0.
- Assert reset during bit 4 of a frame -> all outputs 0; the following clean frame 8'h5A is received correctly.
- Assert rd in the exact stop-sample cycle while rxfull=1 holding 8'h11, new byte 8'h22 -> rxdata=8'h22, rxfull=1, overrun=0.
